// File: rtl/pipe_issue_if.sv
// Handshake and issue-slot bundle between an instruction source, the issue
// controller and the pipelined ALU behind it.
interface pipe_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_rs1;
   logic [3:0]  in_rs2;
   logic [3:0]  in_rd;
   logic [3:0]  in_func;
   logic [7:0]  in_addr;
   logic        halt;
   logic        iss_valid;
   logic [3:0]  iss_rs1;
   logic [3:0]  iss_rs2;
   logic [3:0]  iss_rd;
   logic [3:0]  iss_func;
   logic [7:0]  iss_addr;
   logic        err_illegal;
   logic [15:0] stall_cnt;
   logic [15:0] issue_cnt;

   // Instruction source / supervisor side
   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, halt,
      input  in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr,
             err_illegal, stall_cnt, issue_cnt
   );

   // Issue controller side
   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, halt,
      output in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr,
             err_illegal, stall_cnt, issue_cnt
   );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the 4-stage ALU pipeline: buffers instructions in a
// small FIFO, drops illegal function codes, and holds back any instruction
// whose sources are still being produced by an in-flight instruction.
module pipe_issue_ctrl #(
   parameter int DEPTH  = 4,
   parameter int WB_LAT = 3
) (
   input  logic        clk,
   input  logic        rst,
   pipe_issue_if.slave bus
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // A producer blocks dependents during the WB_LAT-1 decision cycles that
   // follow its issue, so that many tracker slots are needed (at least one
   // slot is kept so the arrays stay legal when WB_LAT is 1).
   localparam int TRK_N = (WB_LAT > 1) ? WB_LAT - 1 : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] rd;
      logic [3:0] func;
      logic [7:0] addr;
   } instr_t;

   // Function codes 12..15 have no ALU operation behind them.
   function automatic logic f_illegal(input logic [3:0] f);
      return f[3] & f[2];
   endfunction

   function automatic logic f_uses_rs1(input logic [3:0] f);
      logic u;
      case (f)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11: u = 1'b1;
         default:                                                       u = 1'b0;
      endcase
      return u;
   endfunction

   function automatic logic f_uses_rs2(input logic [3:0] f);
      logic u;
      case (f)
         4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9: u = 1'b1;
         default:                                        u = 1'b0;
      endcase
      return u;
   endfunction

   instr_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   logic          trk_vld_q [TRK_N];
   logic [3:0]    trk_rd_q  [TRK_N];

   instr_t        iss_q;
   logic          iss_valid_q;
   logic          err_q;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic [15:0]   issue_cnt_q, issue_cnt_d;

   instr_t        in_instr;
   instr_t        head;
   logic          full, empty;
   logic          push, pop, issue, stall, drop;
   logic          hazard;

   assign in_instr = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                       func: bus.in_func, addr: bus.in_addr};
   assign head     = mem_q[rd_ptr_q];
   assign full     = (cnt_q == FULL_CNT);
   assign empty    = (cnt_q == '0);
   assign push     = bus.in_valid & ~full;

   // Compare the head's used sources against every still-young producer.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < TRK_N; i++) begin
         if ((i < WB_LAT - 1) && trk_vld_q[i]) begin
            if (f_uses_rs1(head.func) && (trk_rd_q[i] == head.rs1)) hazard = 1'b1;
            if (f_uses_rs2(head.func) && (trk_rd_q[i] == head.rs2)) hazard = 1'b1;
         end
      end
   end

   // Head decision: drop illegal first, then honour halt, then the interlock.
   always_comb begin
      pop   = 1'b0;
      issue = 1'b0;
      stall = 1'b0;
      drop  = 1'b0;
      if (!empty) begin
         if (f_illegal(head.func)) begin
            pop  = 1'b1;
            drop = 1'b1;
         end else if (bus.halt) begin
            pop = 1'b0;
         end else if (hazard) begin
            stall = 1'b1;
         end else begin
            pop   = 1'b1;
            issue = 1'b1;
         end
      end
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Statistics next-state: stall count saturates, issue count wraps.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      issue_cnt_d = issue_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (issue)                              issue_cnt_d = issue_cnt_q + 16'd1;
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_instr;
   end

   // FIFO control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // In-flight tracker: a shift line that ages every cycle, halted or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TRK_N; i++) begin
            trk_vld_q[i] <= 1'b0;
            trk_rd_q[i]  <= '0;
         end
      end else begin
         trk_vld_q[0] <= issue;
         trk_rd_q[0]  <= head.rd;
         for (int i = 1; i < TRK_N; i++) begin
            trk_vld_q[i] <= trk_vld_q[i-1];
            trk_rd_q[i]  <= trk_rd_q[i-1];
         end
      end
   end

   // Registered issue slot; fields hold their value across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_q       <= '0;
         iss_valid_q <= 1'b0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         iss_valid_q <= issue;
         err_q       <= drop;
         stall_cnt_q <= stall_cnt_d;
         issue_cnt_q <= issue_cnt_d;
         if (issue) iss_q <= head;
      end
   end

   assign bus.in_ready    = ~full;
   assign bus.iss_valid   = iss_valid_q;
   assign bus.iss_rs1     = iss_q.rs1;
   assign bus.iss_rs2     = iss_q.rs2;
   assign bus.iss_rd      = iss_q.rd;
   assign bus.iss_func    = iss_q.func;
   assign bus.iss_addr    = iss_q.addr;
   assign bus.err_illegal = err_q;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.issue_cnt   = issue_cnt_q;

endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
Issue controller that sequences instructions into the 4-stage pipelined ALU (read, execute, writeback, memory store). Instructions arrive over a valid/ready handshake and are buffered in a small FIFO. The controller issues one instruction per cycle to the pipeline's rs1/rs2/rd/func/addr inputs. It interlocks on read-after-write hazards against in-flight destination registers, so the pipeline never reads a stale regbank entry. Illegal function codes are dropped and reported.

Parameters:
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
WB_LAT, 3, minimum cycle distance between a producer's issue cycle and a dependent consumer's issue cycle (range 1..7)

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  FIFO can accept the instruction
in_rs1  input  4  source register A
in_rs2  input  4  source register B
in_rd  input  4  destination register
in_func  input  4  ALU function code
in_addr  input  8  memory store address
halt  input  1  freeze issue; FIFO still accepts
iss_valid  output  1  issue slot holds a real instruction this cycle
iss_rs1  output  4  to pipeline rs1
iss_rs2  output  4  to pipeline rs2
iss_rd  output  4  to pipeline rd
iss_func  output  4  to pipeline func
iss_addr  output  8  to pipeline addr
err_illegal  output  1  one-cycle pulse when an illegal func is dropped
stall_cnt  output  16  saturating count of hazard-stall cycles
issue_cnt  output  16  wrapping count of issued instructions

Behaviour:
- Reset (async, any time, including mid-stream): FIFO emptied, in-flight tracker cleared. iss_valid=0, iss_* fields=0, err_illegal=0, stall_cnt=0, issue_cnt=0. in_ready=1 on the first cycle after reset deassertion.
- FIFO:
  - in_ready = !full, computed from occupancy only. When full, in_ready=0 even if a pop occurs in the same cycle.
  - Push on in_valid & in_ready.
  - Simultaneous push and pop when not full: occupancy unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- Operand usage by func:
  - 0,1,2,5,6,7 use rs1 and rs2.
  - 3,8,10,11 use rs1 only.
  - 4,9 use rs2 only.
  - 12-15 are illegal.
- Head decision, evaluated every cycle the FIFO is non-empty:
  - Illegal func: pop the head, no issue, err_illegal=1 next cycle. This happens regardless of halt and hazard state.
  - halt=1: no pop, iss_valid=0 next cycle, stall_cnt unchanged.
  - Hazard: a used source register equals the rd of any in-flight instruction issued fewer than WB_LAT cycles earlier. Result: no pop, iss_valid=0 next cycle, stall_cnt += 1 (saturates at 16'hFFFF).
  - Otherwise: pop, register the head into iss_* with iss_valid=1 next cycle, issue_cnt += 1, insert rd into the tracker.
- Issue timing:
  - Issue outputs are registered. An instruction entering an empty FIFO at edge k appears on iss_* no earlier than the cycle after edge k+1 (2-cycle minimum latency).
  - Throughput is one issue per cycle when there are no hazards.
- Hazard timing and tracker:
  - Producer A with iss_valid in cycle n: a dependent B has iss_valid no earlier than cycle n+WB_LAT. An independent B may issue at n+1.
  - Tracker entries age every cycle regardless of halt or stall, and expire exactly WB_LAT cycles after issue.
  - rd equal to a source register of the same instruction is not a self-hazard.
- When iss_valid=0, iss_* fields hold their last values. The pipeline must qualify on iss_valid; func default on bubble is don't-care.
- Empty FIFO produces no stall count; only hazard cycles count.
- issue_cnt wraps from 16'hFFFF to 0.

Test Plan:
- Reset then push 3 independent instructions (rd=1,2,3; sources 4..9) back-to-back -> iss_valid high for 3 consecutive cycles starting 2 cycles after the first push; issue_cnt=3; stall_cnt=0.
- Push A (func=0, rd=5) then B (func=0, rs1=5) with WB_LAT=3 -> A issues in cycle n, B in cycle n+3; iss_valid=0 in cycles n+1 and n+2; stall_cnt=2.
- Hazard masking: A rd=5, then B func=4 (uses rs2 only) with rs1=5, rs2=6 -> B issues at n+1, no stall.
- Push 6 instructions with halt=1 and DEPTH=4 -> in_ready=0 after 4 accepted, no issue. Release halt -> 4 issues in order, in_ready reasserts the cycle after the first pop.
- Push func=13 between two legal instructions -> err_illegal pulses once; legal instructions issue on consecutive slots minus one drop cycle; issue_cnt=2.
- Assert rst while 2 instructions are queued and one hazard is pending -> all outputs 0 immediately. After release, a fresh dependent pair behaves as in scenario 2 with no residue from the tracker.
